// File: rtl/mul32_byte_accumulator.sv
// Sequential 32x32 -> 64-bit unsigned multiplier, one 8x8 byte product per cycle.
// Shift-accumulates all 16 byte-pair partial products and hands off on valid/ready.
module mul32_byte_accumulator #(
    parameter int    UUID      = 0,
    parameter string NAME      = "",
    parameter bit    ZERO_SKIP = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] i_msg_64,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] result_64bit,
    output logic [15:0] low_result_16bit,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;

    logic        accept;
    logic        zero_op;
    logic [7:0]  a_byte;
    logic [7:0]  b_byte;
    logic [15:0] pp;
    logic [2:0]  pos;
    logic [5:0]  shamt;
    logic [63:0] pp_shifted;

    assign accept  = in_valid && (state_q == IDLE);
    assign zero_op = (i_msg_64[31:0] == 32'd0) || (i_msg_64[63:32] == 32'd0);

    // i walks A bytes fastest, j walks B bytes; weight of A[i]*B[j] is 2^(8*(i+j)).
    assign a_byte     = a_q[{idx_q[1:0], 3'b000} +: 8];
    assign b_byte     = b_q[{idx_q[3:2], 3'b000} +: 8];
    assign pp         = 16'(a_byte) * 16'(b_byte);
    assign pos        = {1'b0, idx_q[1:0]} + {1'b0, idx_q[3:2]};
    assign shamt      = {pos, 3'b000};
    assign pp_shifted = {48'd0, pp} << shamt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 4'd0;
            acc_q   <= 64'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = (ZERO_SKIP && zero_op) ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (idx_q == 4'd15) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        idx_d = idx_q;
        acc_d = acc_q;
        a_d   = a_q;
        b_d   = b_q;
        if (accept) begin
            a_d   = i_msg_64[31:0];
            b_d   = i_msg_64[63:32];
            idx_d = 4'd0;
            acc_d = 64'd0;
        end else if (state_q == BUSY) begin
            idx_d = idx_q + 4'd1;
            acc_d = acc_q + pp_shifted;
        end
    end

    always_comb begin
        in_ready         = (state_q == IDLE);
        out_valid        = (state_q == DONE);
        busy             = (state_q == BUSY);
        result_64bit     = acc_q;
        low_result_16bit = acc_q[15:0];
    end

endmodule

// File: tb/tb_mul32_byte_accumulator.sv
// Bench for mul32_byte_accumulator: two instances (zero-skip on/off) share stimulus
// and are checked against plain 64-bit multiplication and expected handshake timing.
module tb_mul32_byte_accumulator;

    logic        clk;
    logic        rst;
    logic [63:0] i_msg_64;
    logic        in_valid;
    logic        out_ready;

    logic        s_in_ready, s_out_valid, s_busy;
    logic [63:0] s_result;
    logic [15:0] s_low;
    logic        f_in_ready, f_out_valid, f_busy;
    logic [63:0] f_result;
    logic [15:0] f_low;

    int tests_run;
    int tests_failed;

    mul32_byte_accumulator #(.UUID(1), .NAME("skip"), .ZERO_SKIP(1'b1)) u_skip (
        .clk              (clk),
        .rst              (rst),
        .i_msg_64         (i_msg_64),
        .in_valid         (in_valid),
        .in_ready         (s_in_ready),
        .out_valid        (s_out_valid),
        .out_ready        (out_ready),
        .result_64bit     (s_result),
        .low_result_16bit (s_low),
        .busy             (s_busy)
    );

    mul32_byte_accumulator #(.UUID(2), .NAME("full"), .ZERO_SKIP(1'b0)) u_full (
        .clk              (clk),
        .rst              (rst),
        .i_msg_64         (i_msg_64),
        .in_valid         (in_valid),
        .in_ready         (f_in_ready),
        .out_valid        (f_out_valid),
        .out_ready        (out_ready),
        .result_64bit     (f_result),
        .low_result_16bit (f_low),
        .busy             (f_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Latency n means out_valid is first seen in the cycle ending at edge T+n.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input int hold);
        longint unsigned exp_p;
        int exp_ls, lat_s, lat_f;
        exp_p  = longint'(a) * longint'(b);
        exp_ls = (a == 0 || b == 0) ? 1 : 17;
        check("pre_in_ready_s", {63'd0, s_in_ready}, 64'd1);
        check("pre_in_ready_f", {63'd0, f_in_ready}, 64'd1);
        i_msg_64 = {b, a};
        in_valid = 1'b1;
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        i_msg_64 = {$urandom, $urandom};
        lat_s = 0;
        lat_f = 0;
        for (int n = 1; n <= 40; n++) begin
            if (s_out_valid && lat_s == 0) lat_s = n;
            if (f_out_valid && lat_f == 0) lat_f = n;
            if (n == 3) begin
                in_valid = 1'b1;
                i_msg_64 = {$urandom, $urandom};
            end
            if (n == 4) in_valid = 1'b0;
            if (lat_s != 0 && lat_f != 0) break;
            step();
        end
        in_valid = 1'b0;
        check("lat_skip", 64'(lat_s), 64'(exp_ls));
        check("lat_full", 64'(lat_f), 64'd17);
        check("res_skip", s_result, exp_p);
        check("res_full", f_result, exp_p);
        check("low_full", {48'd0, f_low}, {48'd0, exp_p[15:0]});
        check("done_in_ready", {62'd0, s_in_ready, f_in_ready}, 64'd0);
        check("done_busy", {62'd0, s_busy, f_busy}, 64'd0);
        for (int h = 0; h < hold; h++) begin
            step();
            check("hold_valid", {62'd0, s_out_valid, f_out_valid}, 64'd3);
            check("hold_res", f_result ^ s_result ^ exp_p, exp_p);
            check("hold_in_ready", {62'd0, s_in_ready, f_in_ready}, 64'd0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("post_in_ready", {62'd0, s_in_ready, f_in_ready}, 64'd3);
        check("post_valid", {62'd0, s_out_valid, f_out_valid}, 64'd0);
        check("post_keep", f_result, exp_p);
    endtask

    initial begin
        logic [31:0] ra, rb;
        tests_run    = 0;
        tests_failed = 0;
        rst       = 1'b1;
        i_msg_64  = 64'd0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("rst_in_ready", {62'd0, s_in_ready, f_in_ready}, 64'd3);
        check("rst_out_valid", {62'd0, s_out_valid, f_out_valid}, 64'd0);
        check("rst_busy", {62'd0, s_busy, f_busy}, 64'd0);
        check("rst_result", s_result | f_result, 64'd0);

        run_op(32'd7, 32'd6, 0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);
        run_op(32'h0001_0000, 32'h0001_0000, 0);
        run_op(32'd0, 32'hDEAD_BEEF, 5);
        run_op(32'h1234_5678, 32'd0, 1);

        // abandon a walk partway through
        i_msg_64 = {32'h9ABC_DEF0, 32'h1234_5678};
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 7; k++) step();
        check("mid_busy", {62'd0, s_busy, f_busy}, 64'd3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_in_ready", {62'd0, s_in_ready, f_in_ready}, 64'd3);
        check("abort_out_valid", {62'd0, s_out_valid, f_out_valid}, 64'd0);
        check("abort_result", s_result | f_result, 64'd0);
        run_op(32'd3, 32'd5, 0);

        for (int t = 0; t < 24; t++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: ra = 32'd0;
                1: rb = 32'd0;
                2: ra = 32'(8'($urandom)) << (8 * $urandom_range(0, 3));
                3: rb = 32'hFFFF_FFFF;
                default: ;
            endcase
            run_op(ra, rb, $urandom_range(0, 4));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
